seq_alu: RTL and testbench

//  Parametrised multi-cycle ALU with a start/done handshake; next generation of the lab 4-bit

---
 rtl/seq_alu.sv | 197 +++++++++++++++++++
 tb/tb_seq_alu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU with a start/done handshake: single-cycle logic/add/sub/shift,
// shift-add multiply and restoring divide (one bit per cycle), with N/Z/C/V flags and err.
module seq_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] S_hi,
  output logic             Cout,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             err
);

  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;

  typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_mb, r_rem, r_q;
  logic             r_cin;
  logic [CW-1:0]    r_cnt;
  logic [W2-1:0]    r_prod, r_mc;

  logic             w_fin;
  logic [W1-1:0]    w_sum, w_diff, w_shift, w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_s, w_hi;
  logic             w_cout, w_v, w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_fin  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL)                                   w_next = ST_MUL;
          else if ((op == OP_DIV || op == OP_MOD) && B != '0) w_next = ST_DIV;
          else                                                w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_fin  = 1'b1;
        w_next = ST_DONE;
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == LAST) begin
          w_fin  = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    w_shift = {r_rem, r_q[MSB]};
    w_trial = w_shift - {1'b0, r_b};
    w_ge    = (w_shift >= {1'b0, r_b});
  end

  // Result decode from the latched operands and the finished mul/div registers
  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, r_b} + W1'(r_cin);
    w_diff = {1'b0, r_b} - {1'b0, r_a};
    w_s    = '0;
    w_hi   = '0;
    w_cout = 1'b0;
    w_v    = 1'b0;
    w_err  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_s    = w_sum[MSB:0];
        w_cout = w_sum[WIDTH];
        w_v    = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_s    = w_diff[MSB:0];
        w_cout = w_diff[WIDTH];
        w_v    = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_b[MSB]);
      end
      OP_MUL: begin
        w_s  = r_prod[MSB:0];
        w_hi = r_prod[W2-1:WIDTH];
        w_v  = (r_prod[W2-1:WIDTH] != '0);
      end
      OP_DIV: begin
        w_s   = (r_b == '0) ? '1 : r_q;
        w_err = (r_b == '0);
      end
      OP_MOD: begin
        w_s   = (r_b == '0) ? r_a : r_rem;
        w_err = (r_b == '0);
      end
      OP_AND: w_s = r_a & r_b;
      OP_OR:  w_s = r_a | r_b;
      OP_XOR: w_s = r_a ^ r_b;
      OP_SHL: w_s = r_a << r_b[SHW-1:0];
      OP_SHR: w_s = r_a >> r_b[SHW-1:0];
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_cnt  <= '0;
      r_prod <= '0;
      r_mc   <= '0;
      r_mb   <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      S      <= '0;
      S_hi   <= '0;
      Cout   <= 1'b0;
      N      <= 1'b0;
      Z      <= 1'b1;
      V      <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= w_fin;
      if (r_state == ST_IDLE && start) begin
        r_op   <= op;
        r_a    <= A;
        r_b    <= B;
        r_cin  <= Cin;
        r_cnt  <= '0;
        r_prod <= '0;
        r_mc   <= {WIDTH'(0), A};
        r_mb   <= B;
        r_rem  <= '0;
        r_q    <= A;
        busy   <= 1'b1;
      end
      if (r_state == ST_MUL && r_cnt != LAST) begin
        r_prod <= r_prod + (r_mb[0] ? r_mc : W2'(0));
        r_mc   <= r_mc << 1;
        r_mb   <= r_mb >> 1;
        r_cnt  <= r_cnt + CW'(1);
      end
      if (r_state == ST_DIV && r_cnt != LAST) begin
        r_rem <= w_ge ? w_trial[MSB:0] : w_shift[MSB:0];
        r_q   <= {r_q[MSB-1:0], w_ge};
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_fin) begin
        busy <= 1'b0;
        S    <= w_s;
        S_hi <= w_hi;
        Cout <= w_cout;
        N    <= w_s[MSB];
        Z    <= (w_s == '0);
        V    <= w_v;
        err  <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=4): directed cases plus random operations against an
// arithmetic reference model, including latency, hold, start-while-busy and mid-op reset.
module tb_seq_alu;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, start, Cin;
  logic [3:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done, Cout, N, Z, V, err;
  logic [W-1:0] S, S_hi;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int s; int hi; int cout; int v; int err; int lat;
  } exp_t;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .S_hi(S_hi), .Cout(Cout),
    .N(N), .Z(Z), .V(V), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic exp_t model(input int o, input int a, input int b, input int c);
    exp_t e;
    int   m, half, t, sv, sh;
    m    = 1 << W;
    half = 1 << (W - 1);
    sh   = b % (1 << $clog2(W));
    e    = '{default: 0};
    e.lat = 2;
    case (o)
      1: begin
        t = a + b + c; e.s = t % m; e.cout = int'(t >= m);
        sv = to_signed(a) + to_signed(b) + c; e.v = int'(sv >= half || sv < -half);
      end
      2: begin
        t = b - a; e.s = (t + m) % m; e.cout = int'(b < a);
        sv = to_signed(b) - to_signed(a); e.v = int'(sv >= half || sv < -half);
      end
      3: begin
        t = a * b; e.s = t % m; e.hi = t / m; e.v = int'(e.hi != 0); e.lat = W + 2;
      end
      4: if (b == 0) begin e.s = m - 1; e.err = 1; end
         else begin e.s = a / b; e.lat = W + 2; end
      5: if (b == 0) begin e.s = a; e.err = 1; end
         else begin e.s = a % b; e.lat = W + 2; end
      6: e.s = a & b;
      7: e.s = a | b;
      8: e.s = a ^ b;
      9: e.s = (a << sh) % m;
      10: e.s = a >> sh;
      default: e.err = 1;
    endcase
    return e;
  endfunction

  // Issue one op, optionally hammering start with junk while busy, and check everything
  task automatic run_op(input int o, input int a, input int b, input int c, input bit poke);
    exp_t e;
    int   n;
    e = model(o, a, b, c);
    @(negedge clk);
    op = 4'(o); A = W'(a); B = W'(b); Cin = 1'(c); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    check("busy_after_start", 64'(busy), 64'(1));
    start = poke;
    op = 4'($urandom_range(1, 10)); A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(e.lat));
    check("busy_at_done", 64'(busy), 64'(0));
    check("S", 64'(S), 64'(e.s));
    check("S_hi", 64'(S_hi), 64'(e.hi));
    check("Cout", 64'(Cout), 64'(e.cout));
    check("V", 64'(V), 64'(e.v));
    check("N", 64'(N), 64'((e.s >> (W - 1)) & 1));
    check("Z", 64'(Z), 64'(e.s == 0));
    check("err", 64'(err), 64'(e.err));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("S_hold", 64'(S), 64'(e.s));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_S", 64'(S), 64'(0));
    check("rst_Z", 64'(Z), 64'(1));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b0;

    run_op(1, 3, 6, 0, 0);
    run_op(1, 15, 1, 0, 0);
    run_op(2, 8, 5, 0, 0);
    run_op(2, 3, 10, 0, 0);
    run_op(3, 7, 5, 0, 1);
    run_op(4, 6, 2, 0, 0);
    run_op(5, 3, 10, 0, 0);
    run_op(4, 9, 0, 0, 0);
    run_op(15, 5, 5, 0, 0);
    run_op(6, 6, 6, 0, 0);

    // Reset two cycles into a divide: immediate abort, no done, then normal operation
    @(negedge clk);
    op = 4'd4; A = 4'd9; B = 4'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_S", 64'(S), 64'(0));
    check("midrst_Z", 64'(Z), 64'(1));
    check("midrst_err", 64'(err), 64'(0));
    repeat (W + 2) begin
      @(negedge clk);
      check("midrst_done", 64'(done), 64'(0));
    end
    rst = 1'b0;
    run_op(2, 3, 10, 0, 0);

    for (int i = 0; i < 150; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15))),
             int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
